// File: rtl/tx_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_burst_sequencer
// Description : Gates a free-running PWM into an edge-aligned ping of
//               BURST_CYCLES periods, then times blanking and listen windows.
//               Optional macro TX_DIFF_EN adds complementary drive tx_n_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_burst_sequencer #(
    parameter int BURST_CYCLES  = 8,
    parameter int BLANK_CLOCKS  = 50000,
    parameter int LISTEN_CLOCKS = 2500000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start_in,
    input  logic pwm_in,
    output logic tx_out,
    output logic busy_out,
    output logic listen_out,
    output logic burst_done_out,
    output logic listen_done_out
`ifdef TX_DIFF_EN
    ,
    output logic tx_n_out
`endif
);

    localparam int c_EDGE_W  = $clog2(BURST_CYCLES) + 1;
    localparam int c_TMR_MAX = (BLANK_CLOCKS > LISTEN_CLOCKS) ? BLANK_CLOCKS : LISTEN_CLOCKS;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_BURST  = 3'd2,
        S_BLANK  = 3'd3,
        S_LISTEN = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_pwm_prev;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic [c_TMR_W-1:0]  r_tmr;
    logic                w_rise;
    logic                w_last_edge;
    logic                w_blank_end;
    logic                w_listen_end;

    assign w_rise       = pwm_in & ~r_pwm_prev;
    assign w_last_edge  = (r_edge_cnt == c_EDGE_W'(BURST_CYCLES));
    assign w_blank_end  = (r_tmr == c_TMR_W'(BLANK_CLOCKS - 1));
    assign w_listen_end = (r_tmr == c_TMR_W'(LISTEN_CLOCKS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_in) w_next = S_ALIGN;
            S_ALIGN:  if (w_rise) w_next = S_BURST;
            // The rise that ends the burst is edge BURST_CYCLES+1, so every
            // passed period is complete.
            S_BURST:  if (w_rise && w_last_edge) w_next = S_BLANK;
            S_BLANK:  if (w_blank_end) w_next = S_LISTEN;
            S_LISTEN: if (w_listen_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= S_IDLE;
            r_pwm_prev      <= 1'b0;
            r_edge_cnt      <= '0;
            r_tmr           <= '0;
            tx_out          <= 1'b0;
            busy_out        <= 1'b0;
            listen_out      <= 1'b0;
            burst_done_out  <= 1'b0;
            listen_done_out <= 1'b0;
`ifdef TX_DIFF_EN
            tx_n_out        <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_pwm_prev <= pwm_in;

            if (r_state == S_ALIGN && w_rise) begin
                r_edge_cnt <= c_EDGE_W'(1);
            end else if (r_state == S_BURST && w_rise && !w_last_edge) begin
                r_edge_cnt <= r_edge_cnt + c_EDGE_W'(1);
            end

            // Timer restarts on every state change so each window starts at 0.
            if (w_next != r_state) begin
                r_tmr <= '0;
            end else if (r_state == S_BLANK || r_state == S_LISTEN) begin
                r_tmr <= r_tmr + c_TMR_W'(1);
            end

            tx_out          <= pwm_in & (w_next == S_BURST);
            busy_out        <= (w_next != S_IDLE);
            listen_out      <= (w_next == S_LISTEN);
            burst_done_out  <= (r_state == S_BURST) && (w_next == S_BLANK);
            listen_done_out <= (r_state == S_LISTEN) && (w_next == S_IDLE);
`ifdef TX_DIFF_EN
            tx_n_out        <= ~pwm_in & (w_next == S_BURST);
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
- Turns the free-running 40 kHz square wave from the PWM generator into a ping of exactly BURST_CYCLES whole periods, aligned to a rising edge.
- After the ping it runs a blanking interval, which suppresses transducer ring-down, then a listen window for the echo receive path.
- Sits between the PWM generator and the transducer driver pins.
- Its listen/done strobes time-gate the downstream echo detector.

Parameters:
- BURST_CYCLES, 8, number of full pwm_in periods per ping; legal range ≥1.
- BLANK_CLOCKS, 50000, clk_in cycles in the BLANK state (0.5 ms at 100 MHz); legal range ≥1.
- LISTEN_CLOCKS, 2500000, clk_in cycles in the LISTEN state (25 ms at 100 MHz); legal range ≥1.

Ports:
- clk_in  input  1  system clock; pwm_in is synchronous to it.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  one-cycle ping request; accepted only in IDLE.
- pwm_in  input  1  square wave from the PWM generator.
- tx_out  output  1  gated transducer drive, registered.
- busy_out  output  1  high in every state except IDLE.
- listen_out  output  1  high throughout LISTEN.
- burst_done_out  output  1  one-cycle pulse on the BURST→BLANK transition.
- listen_done_out  output  1  one-cycle pulse on the LISTEN→IDLE transition.

Behaviour:
- Reset:
  - Asserting rst_in at any time, including mid-burst, immediately forces state IDLE.
  - All outputs go to 0, counters clear, and pwm_prev clears to 0.
  - No pulse is emitted on reset.
- Edge detect: register pwm_prev <= pwm_in; rise = pwm_in & ~pwm_prev.
- State machine (state register and counters update on the clk_in rising edge):
  - IDLE: start_in=1 → ALIGN.
  - ALIGN: wait for rise. On rise → BURST, and load edge_cnt=1.
  - BURST: on each rise, if edge_cnt==BURST_CYCLES → BLANK, otherwise edge_cnt+1.
    - The terminating rise is edge number BURST_CYCLES+1, so exactly BURST_CYCLES full periods are passed.
  - BLANK: tmr counts 0..BLANK_CLOCKS-1, then → LISTEN with tmr cleared.
  - LISTEN: tmr counts 0..LISTEN_CLOCKS-1, then → IDLE.
- tx_out:
  - Registered: tx_out <= pwm_in & (next_state==BURST).
  - tx_out therefore equals pwm_in delayed by one clock for the burst's duration.
  - First high cycle is one clock after the aligning rise.
  - Goes low one clock after the terminating rise; no runt pulses.
- Status outputs:
  - busy_out, listen_out and the done pulses are registered from next_state.
  - They change on the same edge as the state register.
  - burst_done_out is high for exactly one cycle, coincident with the first cycle of BLANK.
  - listen_done_out is high for exactly one cycle, coincident with the first IDLE cycle.
- Timing:
  - BLANK occupies exactly BLANK_CLOCKS cycles; LISTEN occupies exactly LISTEN_CLOCKS cycles.
  - Counter widths are $clog2 of each maximum plus 1. There is no wrap-around within a state.
- start_in handling:
  - start_in is ignored whenever busy_out=1; there is no queuing.
  - start_in asserted in the same cycle that LISTEN→IDLE occurs is ignored.
  - start_in in the following cycle is accepted.
- pwm_in phase: if pwm_in is already high when ALIGN is entered, no rise is counted until the next low→high transition.
- pwm_in stuck at a constant level stalls the block in ALIGN or BURST. It recovers only on a rise or on reset. This is intentional, with no timeout.

Optional Feature:
- Macro: TX_DIFF_EN.
- Defined:
  - Adds output port tx_n_out (1 bit), registered, for a differential H-bridge driver.
  - tx_n_out <= ~pwm_in & (next_state==BURST).
  - It is the exact complement of tx_out during BURST and 0 outside BURST.
  - tx_out and tx_n_out are never simultaneously 1. Reset value is 0.
- Undefined: port absent; all other behaviour is identical.

Test Plan:
- Bench configuration: 10-clock pwm_in period, 5 clocks high; BURST_CYCLES=3, BLANK_CLOCKS=20, LISTEN_CLOCKS=50.
- Scenario 1, nominal ping:
  - Stimulus: pulse start_in while pwm_in is low.
  - Required: exactly 3 tx_out high pulses of 5 clocks each, at 10-clock spacing; the first starts 1 clock after the next pwm_in rise.
  - Then burst_done_out is a single pulse; listen_out is high for 50 clocks starting 20 clocks after burst_done_out.
  - listen_done_out pulses once, and busy_out falls on the same edge.
- Scenario 2, mid-high start:
  - Stimulus: start_in asserted while pwm_in is high.
  - Required: tx_out stays 0 until 1 clock after the following rise; still exactly 3 pulses.
- Scenario 3, busy lockout:
  - Stimulus: start_in pulses during BURST, BLANK, LISTEN and the LISTEN→IDLE cycle.
  - Required: all ignored; exactly one ping total. A start_in one cycle later triggers a second ping.
- Scenario 4, asynchronous reset:
  - Stimulus: assert rst_in between clock edges during the 2nd burst pulse.
  - Required: tx_out, busy_out and listen_out go to 0 before the next clk_in edge.
  - After release, outputs stay idle until a new start_in.
- Scenario 5, stalled pwm:
  - Stimulus: hold pwm_in=0 after start_in for 200 clocks, then resume.
  - Required: busy_out=1 and tx_out=0 throughout the stall; a normal 3-pulse burst follows the first rise.
- Scenario 6, TX_DIFF_EN defined:
  - Required: tx_n_out high for the 5 low clocks of each burst period, and 0 outside BURST.
  - tx_out & tx_n_out is 0 on every cycle.
